// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR defaults, accumulator width, MAC FSM states and saturation helper.
package fir_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_COEF_W = 8;
  localparam int DEF_TAPS = 8;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_ACC_W = DEF_DATA_W + DEF_COEF_W + $clog2(DEF_TAPS);
  typedef enum logic {IDLE, ACCUM} state_t;
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/fir_mult_reg.sv
// fir_mult_reg: registered signed sample*coef product with enable and first-tap tags.
module fir_mult_reg #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  localparam int PW = DATA_W + COEF_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     mac_init,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [PW-1:0]     p,
  output logic                     p_vld,
  output logic                     p_first
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p <= '0;
      p_vld <= 1'b0;
      p_first <= 1'b0;
    end else begin
      p <= sample * coef;
      p_vld <= en;
      p_first <= en & mac_init;
    end
  end
endmodule

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: FIR multiply-accumulate, TAPS products per output with a one-cycle valid pulse.
// Define FIR_MAC_SAT_EN to saturate the output; otherwise the low OUT_W bits wrap.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int TAPS = DEF_TAPS,
  parameter int OUT_W = DEF_OUT_W,
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS),
  localparam int PW = DATA_W + COEF_W,
  localparam int CW = $clog2(TAPS + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     mac_init,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [OUT_W-1:0]  y,
  output logic                     valid_out,
  output logic                     busy
);
  logic signed [PW-1:0] p;
  logic p_vld, p_first;
  state_t state, state_n;
  logic signed [ACC_W-1:0] acc, acc_n, p_ext, sum;
  logic [CW-1:0] cnt, cnt_n;
  logic signed [OUT_W-1:0] y_n, y_fmt;
  logic valid_n;

  fir_mult_reg #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_mult (
    .clock(clock), .reset(reset), .en(en), .mac_init(mac_init),
    .sample(sample), .coef(coef), .p(p), .p_vld(p_vld), .p_first(p_first)
  );

  assign p_ext = {{(ACC_W - PW){p[PW-1]}}, p};
  assign sum = acc + p_ext;
  assign busy = state == ACCUM;
`ifdef FIR_MAC_SAT_EN
  assign y_fmt = OUT_W'(sat(64'(sum), OUT_W));
`else
  assign y_fmt = sum[OUT_W-1:0];
`endif

  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    y_n = y;
    valid_n = 1'b0;
    // A first-tap product restarts the frame from either state, dropping any partial sum.
    if (p_vld && p_first) begin
      acc_n = p_ext;
      cnt_n = CW'(1);
      state_n = ACCUM;
    end else if (p_vld && state == ACCUM) begin
      if (cnt == CW'(TAPS - 1)) begin
        y_n = y_fmt;
        valid_n = 1'b1;
        cnt_n = '0;
        state_n = IDLE;
      end else begin
        acc_n = sum;
        cnt_n = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      y <= '0;
      valid_out <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      y <= y_n;
      valid_out <= valid_n;
    end
  end
endmodule

// File: tb/tb_fir_mac_unit.sv
// tb_fir_mac_unit: directed and random frames checked every cycle against a frame-level model.
module tb_fir_mac_unit;
  localparam int TAPS = 8;
  logic clock = 1'b0;
  logic reset, en, mac_init;
  logic signed [7:0] sample, coef;
  logic signed [15:0] y;
  logic valid_out, busy;

  int n_cmp = 0, n_err = 0;
  bit in_frame = 0, pend_v = 0, pend_busy = 0;
  int sum = 0, count = 0, pend_y = 0, cyc = 0, last_v = 0, gap = 0;
  logic signed [15:0] exp_y = 0;

  fir_mac_unit dut (
    .clock(clock), .reset(reset), .en(en), .mac_init(mac_init),
    .sample(sample), .coef(coef), .y(y), .valid_out(valid_out), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic signed [15:0] fmt(int s);
`ifdef FIR_MAC_SAT_EN
    return s > 32767 ? 16'sh7fff : s < -32768 ? 16'sh8000 : 16'(s);
`else
    return 16'(s);
`endif
  endfunction

  task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(bit e, bit mi, int s, int c);
    int prod;
    en = e;
    mac_init = mi;
    sample = 8'(s);
    coef = 8'(c);
    @(posedge clock);
    #1;
    cyc++;
    if (pend_v) exp_y = 16'(pend_y);
    check("valid_out", 32'(valid_out), 32'(pend_v));
    check("busy", 32'(busy), 32'(pend_busy));
    check("y", y, exp_y);
    if (valid_out) begin
      gap = cyc - last_v;
      last_v = cyc;
    end
    pend_v = 0;
    if (e) begin
      prod = int'(sample) * int'(coef);
      if (mi) begin
        in_frame = 1;
        sum = prod;
        count = 1;
      end else if (in_frame) begin
        sum += prod;
        count++;
        if (count == TAPS) begin
          pend_v = 1;
          pend_y = int'(fmt(sum));
          in_frame = 0;
        end
      end
    end
    pend_busy = in_frame;
  endtask

  task automatic hit_reset();
    reset = 1'b1;
    #1;
    in_frame = 0;
    pend_v = 0;
    pend_busy = 0;
    exp_y = 0;
    check("rst_y", y, 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_busy", 32'(busy), 0);
    en = 1'b0;
    mac_init = 1'b0;
    @(posedge clock);
    #1;
    cyc++;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    mac_init = 1'b0;
    sample = '0;
    coef = '0;
    repeat (2) @(posedge clock);
    #1;
    check("init_y", y, 0);
    check("init_valid", 32'(valid_out), 0);
    check("init_busy", 32'(busy), 0);
    reset = 1'b0;

    for (int i = 0; i < TAPS; i++) step(1, i == 0, 1, i + 1);
    repeat (2) step(0, 0, 0, 0);
    check("y36", y, 36);
    check("latency", last_v, 9);

    for (int i = 0; i < TAPS; i++) step(1, i == 0, -1, i + 1);
    repeat (2) step(0, 0, 0, 0);
    check("y_neg36", y, -36);

    for (int i = 0; i < TAPS; i++) step(1, i == 0, -128, -128);
    repeat (2) step(0, 0, 0, 0);
`ifdef FIR_MAC_SAT_EN
    check("y_big", y, 32767);
`else
    check("y_big", y, 0);
`endif

    for (int i = 0; i < TAPS; i++) begin
      step(1, i == 0, 1, i + 1);
      if (i == 3) repeat (2) step(0, 0, 7, 7);
    end
    repeat (2) step(0, 0, 0, 0);
    check("y_gap", y, 36);

    for (int i = 0; i < 5; i++) step(1, i == 0, 5, 9);
    for (int i = 0; i < TAPS; i++) step(1, i == 0, 1, i + 1);
    for (int i = 0; i < TAPS; i++) step(1, i == 0, 2, i + 1);
    repeat (2) step(0, 0, 0, 0);
    check("y_b2b", y, 72);
    check("b2b_gap", gap, 8);

    for (int i = 0; i < 4; i++) step(1, i == 0, 3, 3);
    hit_reset();
    for (int i = 0; i < TAPS; i++) step(1, 0, 4, 4);
    repeat (2) step(0, 0, 0, 0);
    check("y_after_rst", y, 0);

    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < TAPS; i++) begin
        while ($urandom_range(3) == 0) step(0, $urandom_range(1), $urandom, $urandom);
        step(1, i == 0 || $urandom_range(40) == 0, $urandom, $urandom);
      end
    end
    repeat (3) step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fir_mac_unit.md
# fir_mac_unit

Multiply-accumulate datapath of the FIR filter, directly downstream of the FIR control unit. Each enabled cycle it multiplies one sample from the sample RAM by one coefficient from the coefficient ROM, sums TAPS products per output sample and presents the filtered result with a one-cycle valid pulse. It consumes the control unit's `en` and `mac_init` strobes and the RAM/ROM read data addressed by it.

## Interface
- `DATA_W`, 8: signed sample width
- `COEF_W`, 8: signed coefficient width
- `TAPS`, 8: products per output sample (≥2)
- `OUT_W`, 16: output width; accumulator width ACC_W = DATA_W+COEF_W+$clog2(TAPS)

Ports:
- `clock` in 1: single clock; all state updates on rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `en` in 1: product enable from control unit; one tap per cycle while high
- `mac_init` in 1: marks the first tap of a frame when sampled with `en`
- `sample` in DATA_W: signed sample from sample RAM
- `coef` in COEF_W: signed coefficient from coefficient ROM
- `y` out OUT_W: signed filter output, held until next result
- `valid_out` out 1: one-cycle pulse, `y` updated this cycle
- `busy` out 1: high while a frame is accumulating

## Operation
- Reset values: `y`=0, `valid_out`=0, `busy`=0; product register, tags, accumulator, tap counter all 0; FSM in IDLE.
- Stage 1 (every edge): p <= sample*coef (signed, DATA_W+COEF_W bits); p_vld <= en; p_first <= en & mac_init.
- FSM states IDLE, ACCUM.
  - IDLE: p_vld & p_first -> acc <= sext(p), tap_cnt <= 1, go ACCUM. p_vld without p_first: product discarded.
  - ACCUM: p_vld & !p_first -> acc <= acc + sext(p), tap_cnt++. p_vld clear -> hold (bubble).
  - ACCUM, p_vld & p_first before TAPS reached: abort current frame, restart with this product; no `valid_out` for aborted frame.
  - Product completing tap TAPS: y <= fmt(acc + sext(p)), valid_out <= 1, go IDLE (or, if that product also carries p_first, which is impossible with tap_cnt=TAPS-1, not considered).
- Back-to-back frames: p_first may arrive the cycle after the last tap completes; handled from IDLE with no gap.
- `busy` = (state == ACCUM).
- Accumulator at ACC_W never overflows; fmt() reduces ACC_W to OUT_W per Configuration.
- Reset mid-frame: partial sum discarded, no `valid_out`, first frame after release needs a fresh `mac_init`.

## Timing
- Multiply latency 1 cycle; accumulation 1 cycle per product.
- With tap 0 sampled in cycle 0 and no `en` gaps, `valid_out` high in cycle TAPS+1 (cycle 9 for TAPS=8), exactly one cycle.
- Each low-`en` cycle inside a frame adds one cycle of latency.
- `y` changes only in the cycle `valid_out` is high.

## Configuration
- `FIR_MAC_SAT_EN` defined: fmt() saturates to OUT_W signed range (max 2^(OUT_W-1)-1, min -2^(OUT_W-1)).
- Not defined: fmt() keeps the low OUT_W bits (two's-complement wrap).

## Structure
- Shared package `fir_pkg`: DATA_W/COEF_W/TAPS/OUT_W defaults, ACC_W derivation, FSM state typedef (IDLE, ACCUM), saturation helper function.
- One sub-module: `fir_mult_reg` (registered signed multiplier, stage 1 plus tags).

## Test plan
- Samples all 1, coefs 1..8, mac_init with tap 0 -> y=36, valid_out in cycle 9, one cycle wide.
- Samples all -1, coefs 1..8 -> y=-36.
- All samples -128, coefs -128 -> with FIR_MAC_SAT_EN y=32767; without y=0 (131072 mod 65536).
- `en` low for 2 cycles between taps 3 and 4 -> y unchanged (36), valid_out in cycle 11.
- mac_init reasserted at tap 5, then 8 clean taps -> single valid_out, y from new frame only; back-to-back frames give valid_out 8 cycles apart.
- reset asserted at tap 4 -> outputs 0 immediately, no valid_out; taps without mac_init afterwards ignored.
